mem_port_arbiter: RTL and testbench

Shares the core's single synchronous RAM port between two requesters. The instruction-fetch requester is driven by the microcode buffer's PC/head logic. The data requester is driven by load/store microcode. Each cycle the block picks at most one requester, drives the RAM address/write-enable/write-data, and routes the read data back one cycle later. Data accesses have priority, with a bounded-streak rule so that fetch cannot starve.

---
 rtl/mem_port_arbiter.sv | 110 +++++++++++
 tb/tb_mem_port_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-way arbiter for the core's single synchronous RAM port.
// The data requester normally wins. A bounded streak counter forces a
// pending fetch through after MAX_DATA_STREAK back-to-back data grants.
// Read data is routed back one cycle after the grant to whichever
// requester issued the read.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH      = 8,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_gnt,
  output logic                  fetch_rvalid,
  output logic [DATA_WIDTH-1:0] fetch_rdata,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic                  data_gnt,
  output logic                  data_rvalid,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  logic [3:0] streak;
  logic [3:0] streak_next;
  owner_t     rd_owner;
  owner_t     rd_owner_next;

  // Pick at most one requester; data wins unless fetch has waited out a full streak.
  always_comb begin
    fetch_gnt = 1'b0;
    data_gnt  = 1'b0;
    if (!rst) begin
      if (data_req && !(fetch_req && (streak == STREAK_MAX))) begin
        data_gnt = 1'b1;
      end else if (fetch_req) begin
        fetch_gnt = 1'b1;
      end
    end
  end

  // Steer the granted requester onto the RAM port; an idle port drives zeros.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (data_gnt) begin
      mem_addr  = data_addr;
      mem_we    = data_we;
      mem_wdata = data_wdata;
    end else if (fetch_gnt) begin
      mem_addr  = fetch_addr;
    end
  end

  // Count data grants that overtook a waiting fetch; cleared once fetch is served or withdraws.
  always_comb begin
    streak_next = streak;
    if (!fetch_req || fetch_gnt) begin
      streak_next = 4'd0;
    end else if (data_gnt && (streak < STREAK_MAX)) begin
      streak_next = streak + 4'd1;
    end
  end

  // Remember who issued a read this cycle so the RAM data can be routed next cycle.
  always_comb begin
    rd_owner_next = OWN_NONE;
    if (fetch_gnt) begin
      rd_owner_next = OWN_FETCH;
    end else if (data_gnt && !data_we) begin
      rd_owner_next = OWN_DATA;
    end
  end

  // State registers for the streak counter and the read owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak   <= 4'd0;
      rd_owner <= OWN_NONE;
    end else begin
      streak   <= streak_next;
      rd_owner <= rd_owner_next;
    end
  end

  // Return read data to its owner; a response in flight when reset arrives is squashed.
  always_comb begin
    fetch_rvalid = (rd_owner == OWN_FETCH) && !rst;
    data_rvalid  = (rd_owner == OWN_DATA) && !rst;
    fetch_rdata  = fetch_rvalid ? mem_rdata : '0;
    data_rdata   = data_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural RAM.
// Inputs change just after the rising edge; outputs are sampled on the
// falling edge of the same cycle.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        fetch_req;
  logic [7:0]  fetch_addr;
  logic        fetch_gnt;
  logic        fetch_rvalid;
  logic [31:0] fetch_rdata;
  logic        data_req;
  logic        data_we;
  logic [7:0]  data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] ram [256];

  int compared   = 0;
  int mismatched = 0;

  mem_port_arbiter #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(32),
    .MAX_DATA_STREAK(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fetch_req(fetch_req),
    .fetch_addr(fetch_addr),
    .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid),
    .fetch_rdata(fetch_rdata),
    .data_req(data_req),
    .data_we(data_we),
    .data_addr(data_addr),
    .data_wdata(data_wdata),
    .data_gnt(data_gnt),
    .data_rvalid(data_rvalid),
    .data_rdata(data_rdata),
    .mem_addr(mem_addr),
    .mem_we(mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous RAM: write on the edge, read data one cycle after the address.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic fr, input logic [7:0] fa,
                               input logic dr, input logic dwe, input logic [7:0] da,
                               input logic [31:0] dwd);
    @(posedge clk);
    #1;
    rst        = r;
    fetch_req  = fr;
    fetch_addr = fa;
    data_req   = dr;
    data_we    = dwe;
    data_addr  = da;
    data_wdata = dwd;
    @(negedge clk);
  endtask

  // Main directed sequence.
  initial begin
    bit exp_f [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    bit drop_f [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    bit prev_f;
    bit prev_d;

    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[8'h05] = 32'hA5A5_0005;
    ram[8'h10] = 32'hDEAD_BEEF;
    rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0;

    // Reset held two cycles with both requesters active.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 8'h44, 32'hCAFE_F00D);
      checkOutput("rst_fetch_gnt", 32'(fetch_gnt), 32'd0);
      checkOutput("rst_data_gnt", 32'(data_gnt), 32'd0);
      checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
      checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
      checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
      checkOutput("rst_fetch_rvalid", 32'(fetch_rvalid), 32'd0);
      checkOutput("rst_data_rvalid", 32'(data_rvalid), 32'd0);
    end

    // First cycle after release: data wins.
    applyStimulus(1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 8'h05, 32'h0);
    checkOutput("post_rst_data_gnt", 32'(data_gnt), 32'd1);
    checkOutput("post_rst_fetch_gnt", 32'(fetch_gnt), 32'd0);
    checkOutput("post_rst_mem_addr", 32'(mem_addr), 32'h05);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
    checkOutput("post_rst_data_rvalid", 32'(data_rvalid), 32'd1);
    checkOutput("post_rst_data_rdata", data_rdata, 32'hA5A5_0005);
    checkOutput("post_rst_fetch_rvalid", 32'(fetch_rvalid), 32'd0);

    // Single fetch.
    applyStimulus(1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 32'h0);
    checkOutput("fetch_gnt", 32'(fetch_gnt), 32'd1);
    checkOutput("fetch_data_gnt", 32'(data_gnt), 32'd0);
    checkOutput("fetch_mem_addr", 32'(mem_addr), 32'h10);
    checkOutput("fetch_mem_we", 32'(mem_we), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
    checkOutput("fetch_rvalid", 32'(fetch_rvalid), 32'd1);
    checkOutput("fetch_rdata", fetch_rdata, 32'hDEAD_BEEF);
    checkOutput("fetch_data_rvalid", 32'(data_rvalid), 32'd0);
    checkOutput("fetch_data_rdata", data_rdata, 32'd0);

    // Write then read of the same address.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 32'h1234_5678);
    checkOutput("wr_data_gnt", 32'(data_gnt), 32'd1);
    checkOutput("wr_mem_we", 32'(mem_we), 32'd1);
    checkOutput("wr_mem_addr", 32'(mem_addr), 32'h20);
    checkOutput("wr_mem_wdata", mem_wdata, 32'h1234_5678);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h20, 32'h0);
    checkOutput("wr_no_rvalid", 32'(data_rvalid), 32'd0);
    checkOutput("rd_data_gnt", 32'(data_gnt), 32'd1);
    checkOutput("rd_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rd_mem_wdata", mem_wdata, 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
    checkOutput("rd_data_rvalid", 32'(data_rvalid), 32'd1);
    checkOutput("rd_data_rdata", data_rdata, 32'h1234_5678);

    // Starvation bound: both requesters held for 12 cycles.
    prev_f = 1'b0;
    prev_d = 1'b0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 8'h05, 32'h0);
      checkOutput($sformatf("starve_fetch_gnt[%0d]", i), 32'(fetch_gnt), 32'(exp_f[i]));
      checkOutput($sformatf("starve_data_gnt[%0d]", i), 32'(data_gnt), 32'(!exp_f[i]));
      checkOutput($sformatf("starve_fetch_rvalid[%0d]", i), 32'(fetch_rvalid), 32'(prev_f));
      checkOutput($sformatf("starve_data_rvalid[%0d]", i), 32'(data_rvalid), 32'(prev_d));
      checkOutput($sformatf("starve_fetch_rdata[%0d]", i), fetch_rdata, prev_f ? 32'hDEAD_BEEF : 32'h0);
      checkOutput($sformatf("starve_data_rdata[%0d]", i), data_rdata, prev_d ? 32'hA5A5_0005 : 32'h0);
      prev_f = exp_f[i];
      prev_d = !exp_f[i];
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);

    // Fetch withdraws for one cycle, clearing the streak.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, (i != 3), 8'h10, 1'b1, 1'b0, 8'h05, 32'h0);
      checkOutput($sformatf("drop_fetch_gnt[%0d]", i), 32'(fetch_gnt), 32'(drop_f[i]));
      checkOutput($sformatf("drop_data_gnt[%0d]", i), 32'(data_gnt), 32'(!drop_f[i]));
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);

    // Reset arriving while a fetch read is in flight.
    applyStimulus(1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 32'h0);
    checkOutput("midrst_fetch_gnt", 32'(fetch_gnt), 32'd1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
    checkOutput("midrst_rvalid_n1", 32'(fetch_rvalid), 32'd0);
    checkOutput("midrst_rdata_n1", fetch_rdata, 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
    checkOutput("midrst_rvalid_n2", 32'(fetch_rvalid), 32'd0);

    // Resume, build a partial streak, then reset must restart it from zero.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 8'h05, 32'h0);
      checkOutput($sformatf("resume_data_gnt[%0d]", i), 32'(data_gnt), 32'd1);
    end
    applyStimulus(1'b1, 1'b1, 8'h10, 1'b1, 1'b0, 8'h05, 32'h0);
    checkOutput("streak_rst_data_gnt", 32'(data_gnt), 32'd0);
    checkOutput("streak_rst_fetch_gnt", 32'(fetch_gnt), 32'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 8'h05, 32'h0);
      checkOutput($sformatf("restart_fetch_gnt[%0d]", i), 32'(fetch_gnt), 32'(i == 4));
      checkOutput($sformatf("restart_data_gnt[%0d]", i), 32'(data_gnt), 32'(i != 4));
    end

    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
